// File: rtl/branch_pkg.sv
// Shared constants and result type for the branch resolution stage.
// Optional statistics counters are enabled with BRANCH_STATS_EN.
package branch_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    typedef struct packed {
        logic            taken;
        logic            taken_b;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] next_pc;
    } br_result_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational funct3 decode of comparator flags into per-lane branch conditions.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       mode_i,
    input  logic       eq_a_i,
    input  logic       slt_a_i,
    input  logic       ult_a_i,
    input  logic       eq_b_i,
    input  logic       slt_b_i,
    input  logic       ult_b_i,
    output logic       taken_o,
    output logic       taken_b_o,
    output logic       illegal_o
);

    // Illegal encodings fall into the default arm and resolve not-taken.
    function automatic logic cond_hit(input logic [2:0] op, input logic eq,
                                      input logic slt, input logic ult);
        case (op)
            F3_BEQ:  cond_hit = eq;
            F3_BNE:  cond_hit = !eq;
            F3_BLT:  cond_hit = slt;
            F3_BGE:  cond_hit = !slt;
            F3_BLTU: cond_hit = ult;
            F3_BGEU: cond_hit = !ult;
            default: cond_hit = 1'b0;
        endcase
    endfunction

    assign illegal_o = (op_i == 3'b010) || (op_i == 3'b011);
    assign taken_o   = cond_hit(op_i, eq_a_i, slt_a_i, ult_a_i);
    assign taken_b_o = !mode_i && cond_hit(op_i, eq_b_i, slt_b_i, ult_b_i);

endmodule

// File: rtl/branch_resolve.sv
module branch_resolve
  import branch_pkg::*;
#(
  parameter int STAT_W = 32
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [2:0]      in_op,
  input  logic            in_eqA,
  input  logic            in_sltA,
  input  logic            in_ultA,
  input  logic            in_eqB,
  input  logic            in_sltB,
  input  logic            in_ultB,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_target,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_taken_b,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_next_pc
`ifdef BRANCH_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  logic       c_taken, c_taken_b, c_illegal;
  br_result_t res_in;
  br_result_t main_q, main_d, skid_q, skid_d;
  logic       main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic       in_fire, out_fire;

  branch_cond_eval u_cond (
    .op_i      (in_op),
    .mode_i    (in_mode),
    .eq_a_i    (in_eqA),
    .slt_a_i   (in_sltA),
    .ult_a_i   (in_ultA),
    .eq_b_i    (in_eqB),
    .slt_b_i   (in_sltB),
    .ult_b_i   (in_ultB),
    .taken_o   (c_taken),
    .taken_b_o (c_taken_b),
    .illegal_o (c_illegal)
  );

  always_comb begin
    res_in.taken      = c_taken;
    res_in.taken_b    = c_taken_b;
    res_in.illegal    = c_illegal;
    res_in.mispredict = c_taken ^ in_pred_taken;
    res_in.next_pc    = c_taken ? in_target : in_pc + PC_INC;
  end

  assign in_ready = !skid_vld_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_d     = res_in;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = res_in;
      skid_vld_d = 1'b1;
    end
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign out_valid      = main_vld_q;
  assign out_taken      = main_vld_q && main_q.taken;
  assign out_taken_b    = main_vld_q && main_q.taken_b;
  assign out_mispredict = main_vld_q && main_q.mispredict;
  assign out_illegal    = main_vld_q && main_q.illegal;
  assign out_next_pc    = main_q.next_pc;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (stat_clr) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else if (out_fire) begin
      if (br_cnt_q != '1)
        br_cnt_d = br_cnt_q + 1'b1;
      if (out_mispredict && mp_cnt_q != '1)
        mp_cnt_d = mp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  import branch_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, in_mode;
  logic [2:0]      in_op;
  logic            in_eqA, in_sltA, in_ultA, in_eqB, in_sltB, in_ultB;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pc, in_target;
  logic            flush;
  logic            out_valid, out_ready;
  logic            out_taken, out_taken_b, out_mispredict, out_illegal;
  logic [XLEN-1:0] out_next_pc;
`ifdef BRANCH_STATS_EN
  logic            stat_clr;
  logic [2:0]      stat_branches, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolve #(.STAT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_op(in_op),
    .in_eqA(in_eqA), .in_sltA(in_sltA), .in_ultA(in_ultA),
    .in_eqB(in_eqB), .in_sltB(in_sltB), .in_ultB(in_ultB),
    .in_pred_taken(in_pred_taken), .in_pc(in_pc), .in_target(in_target),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_taken_b(out_taken_b),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .out_next_pc(out_next_pc)
`ifdef BRANCH_STATS_EN
    ,
    .stat_clr(stat_clr), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    logic            mode;
    logic [2:0]      op;
    logic            eqa, slta, ulta, eqb, sltb, ultb;
    logic            pred;
    logic [XLEN-1:0] pc, tgt;
    logic            e_t, e_tb, e_mp, e_il;
    logic [XLEN-1:0] e_npc;
  } vec_t;

  vec_t vecs[13];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    in_mode = v.mode; in_op = v.op;
    in_eqA = v.eqa; in_sltA = v.slta; in_ultA = v.ulta;
    in_eqB = v.eqb; in_sltB = v.sltb; in_ultB = v.ultb;
    in_pred_taken = v.pred; in_pc = v.pc; in_target = v.tgt;
  endtask

  task automatic apply_beq_pc(input logic [XLEN-1:0] pc);
    in_mode = 1'b1; in_op = F3_BEQ;
    in_eqA = 1'b0; in_sltA = 1'b0; in_ultA = 1'b0;
    in_eqB = 1'b0; in_sltB = 1'b0; in_ultB = 1'b0;
    in_pred_taken = 1'b0; in_pc = pc; in_target = 64'hDEAD_0000;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1000, 64'h2000, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2000};
    vecs[1]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100,  64'h300,  1'b1, 1'b0, 1'b0, 1'b0, 64'h300};
    vecs[2]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100,  64'h300,  1'b1, 1'b0, 1'b0, 1'b0, 64'h300};
    vecs[3]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h100,  64'h300,  1'b1, 1'b1, 1'b0, 1'b0, 64'h300};
    vecs[4]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h100,  64'h300,  1'b1, 1'b0, 1'b0, 1'b0, 64'h300};
    vecs[5]  = '{1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0};
    vecs[6]  = '{1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h500,  64'h40,   1'b0, 1'b0, 1'b0, 1'b1, 64'h504};
    vecs[7]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h600,  64'h800,  1'b1, 1'b0, 1'b0, 1'b0, 64'h800};
    vecs[8]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h600,  64'h800,  1'b0, 1'b1, 1'b0, 1'b0, 64'h604};
    vecs[9]  = '{1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h700,  64'h900,  1'b1, 1'b0, 1'b1, 1'b0, 64'h900};
    vecs[10] = '{1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h700,  64'h900,  1'b0, 1'b1, 1'b1, 1'b0, 64'h704};
    vecs[11] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h1000, 64'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1004};
    vecs[12] = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b1, 1'b0, 1'b0, 1'b0, 64'h40};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
`ifdef BRANCH_STATS_EN
    stat_clr = 1'b0;
`endif
    apply(vecs[0]);
    tick(); tick();
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.taken", out_taken, 1'b0);
    chk("rst.taken_b", out_taken_b, 1'b0);
    chk("rst.mispredict", out_mispredict, 1'b0);
    chk("rst.illegal", out_illegal, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("rst.stat_branches", stat_branches, 3'd0);
    chk("rst.stat_mispredicts", stat_mispredicts, 3'd0);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst.out_valid", out_valid, 1'b0);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d.valid", i), out_valid, 1'b1);
      chk($sformatf("v%0d.taken", i), out_taken, vecs[i].e_t);
      chk($sformatf("v%0d.taken_b", i), out_taken_b, vecs[i].e_tb);
      chk($sformatf("v%0d.mispredict", i), out_mispredict, vecs[i].e_mp);
      chk($sformatf("v%0d.illegal", i), out_illegal, vecs[i].e_il);
      chk($sformatf("v%0d.next_pc", i), out_next_pc, vecs[i].e_npc);
      tick();
      chk($sformatf("v%0d.drained", i), out_valid, 1'b0);
    end

    out_ready = 1'b0;
    apply_beq_pc(64'h10); in_valid = 1'b1;
    tick();
    chk("bp.ready_after_A", in_ready, 1'b1);
    apply_beq_pc(64'h20);
    tick();
    chk("bp.ready_after_B", in_ready, 1'b0);
    apply_beq_pc(64'h30);
    tick();
    chk("bp.hold_valid", out_valid, 1'b1);
    chk("bp.hold_A", out_next_pc, 64'h14);
    chk("bp.stall_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp.out_B", out_next_pc, 64'h24);
    chk("bp.ready_rise", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp.out_C_valid", out_valid, 1'b1);
    chk("bp.out_C", out_next_pc, 64'h34);
    tick();
    chk("bp.empty", out_valid, 1'b0);

    out_ready = 1'b0;
    apply_beq_pc(64'h40); in_valid = 1'b1;
    tick();
    apply_beq_pc(64'h50);
    tick();
    chk("fl.full", in_ready, 1'b0);
    apply_beq_pc(64'h60);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.out_valid", out_valid, 1'b0);
    chk("fl.in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("fl.no_ghost", out_valid, 1'b0);

`ifdef BRANCH_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st.cleared", stat_branches, 3'd0);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: apply(vecs[0]);
        1: apply(vecs[1]);
        2: apply(vecs[5]);
        3: apply(vecs[7]);
        default: apply(vecs[8]);
      endcase
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("st.branches5", stat_branches, 3'd5);
    chk("st.mispredicts2", stat_mispredicts, 3'd2);
    apply(vecs[0]); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st.clr_br", stat_branches, 3'd0);
    chk("st.clr_mp", stat_mispredicts, 3'd0);
    apply(vecs[0]); in_valid = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    in_valid = 1'b0;
    tick();
    chk("st.sat_br", stat_branches, 3'd7);
    chk("st.sat_mp", stat_mispredicts, 3'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
